// File: rtl/fourier_synthesizer_ramped.sv
// Sums N amplitude-scaled DDS tones through a registered adder tree, applies a global ramp envelope,
// a DC offset and DAC-range saturation with sticky clip flags.
module fourier_synthesizer_ramped #(
    parameter int unsigned N_CHANNELS       = 4,
    parameter int unsigned AXIS_TDATA_WIDTH = 16,
    parameter int unsigned AMP_WIDTH        = 16,
    parameter int unsigned AMP_SHIFT        = 13,
    parameter int unsigned RAMP_WIDTH       = 16,
    parameter int unsigned DAC_WIDTH        = 14
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [N_CHANNELS*AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [N_CHANNELS-1:0]                  s_axis_tvalid,
    output logic [N_CHANNELS-1:0]                  s_axis_tready,
    input  logic [N_CHANNELS*AMP_WIDTH-1:0]        amplitude,
    input  logic signed [DAC_WIDTH-1:0]            offset,
    input  logic                                   ramp_enable,
    input  logic [RAMP_WIDTH-1:0]                  ramp_step,
    input  logic                                   clear_sat,
    output logic [AXIS_TDATA_WIDTH-1:0]            m_axis_tdata,
    output logic                                   m_axis_tvalid,
    output logic [1:0]                             ramp_state,
    output logic                                   sat_pos,
    output logic                                   sat_neg
);

    localparam int unsigned W   = AXIS_TDATA_WIDTH;
    localparam int unsigned PW  = W + AMP_WIDTH + 1;
    localparam int unsigned LV  = $clog2(N_CHANNELS);
    localparam int unsigned NP  = 1 << LV;
    localparam int unsigned SW  = PW + LV;
    localparam int unsigned SCW = SW + RAMP_WIDTH + 2;
    localparam int unsigned VW  = SCW + 1;
    localparam int unsigned SH  = AMP_SHIFT + RAMP_WIDTH;
    localparam int unsigned L   = 4 + LV;

    localparam logic [RAMP_WIDTH:0]     ACC_MAX = {1'b1, {RAMP_WIDTH{1'b0}}};
    localparam logic signed [VW-1:0]    SAT_HI  = VW'({1'b0, {(DAC_WIDTH-1){1'b1}}});
    localparam logic signed [VW-1:0]    SAT_LO  = ~SAT_HI;

    typedef enum logic [1:0] {
        StOff  = 2'b00,
        StUp   = 2'b01,
        StOn   = 2'b10,
        StDown = 2'b11
    } ramp_state_e;

    ramp_state_e              r_state, w_state_d;
    logic [RAMP_WIDTH:0]      r_acc, w_acc_d;
    logic [RAMP_WIDTH+1:0]    w_acc_up;
    logic [RAMP_WIDTH:0]      w_acc_dn;

    logic signed [SW-1:0]     w_leaf [NP];
    // Heap-ordered tree: leaves at NP..2NP-1 (stage M), node 1 is the full sum.
    logic signed [SW-1:0]     r_node [1:2*NP-1];
    logic signed [RAMP_WIDTH+1:0] w_gain;
    logic signed [SCW-1:0]    r_scaled;
    logic signed [SCW-1:0]    w_shifted;
    logic signed [VW-1:0]     r_v;
    logic                     w_clip_hi, w_clip_lo;
    logic signed [DAC_WIDTH-1:0] r_out;
    logic [L-1:0]             r_vld;
    logic                     r_sat_pos, r_sat_neg;

    assign s_axis_tready = '1;

    for (genvar gi = 0; gi < NP; gi++) begin : g_leaf
        if (gi < N_CHANNELS) begin : g_ch
            logic signed [W-1:0]         w_data;
            logic signed [AMP_WIDTH:0]   w_amp;
            logic signed [PW-1:0]        w_prod;
            assign w_data = s_axis_tdata[gi*W +: W];
            assign w_amp  = {1'b0, amplitude[gi*AMP_WIDTH +: AMP_WIDTH]};
            assign w_prod = w_data * w_amp;
            assign w_leaf[gi] = s_axis_tvalid[gi] ? SW'(w_prod) : '0;
        end else begin : g_pad
            assign w_leaf[gi] = '0;
        end
    end

    // Ramp FSM: step = 0 lands directly on the end point.
    always_comb begin
        w_state_d = r_state;
        w_acc_d   = r_acc;
        w_acc_up  = {1'b0, r_acc} + {2'b00, ramp_step};
        w_acc_dn  = r_acc - {1'b0, ramp_step};
        if (ramp_enable && r_state != StOn) begin
            if (ramp_step == '0 || w_acc_up >= {1'b0, ACC_MAX}) begin
                w_acc_d   = ACC_MAX;
                w_state_d = StOn;
            end else begin
                w_acc_d   = w_acc_up[RAMP_WIDTH:0];
                w_state_d = StUp;
            end
        end else if (!ramp_enable && r_state != StOff) begin
            if (ramp_step == '0 || r_acc <= {1'b0, ramp_step}) begin
                w_acc_d   = '0;
                w_state_d = StOff;
            end else begin
                w_acc_d   = w_acc_dn;
                w_state_d = StDown;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StOff;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_d;
            r_acc   <= w_acc_d;
        end
    end

    assign w_gain    = {1'b0, r_acc};
    assign w_shifted = r_scaled >>> SH;
    assign w_clip_hi = r_v > SAT_HI;
    assign w_clip_lo = r_v < SAT_LO;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k < 2 * NP; k++) r_node[k] <= '0;
            r_scaled  <= '0;
            r_v       <= '0;
            r_out     <= '0;
            r_vld     <= '0;
            r_sat_pos <= 1'b0;
            r_sat_neg <= 1'b0;
        end else begin
            for (int k = 0; k < NP; k++) r_node[NP+k] <= w_leaf[k];
            for (int k = 1; k < NP; k++) r_node[k] <= r_node[2*k] + r_node[2*k+1];
            r_scaled <= r_node[1] * w_gain;
            r_v      <= VW'(w_shifted) + VW'(offset);
            if (w_clip_hi) begin
                r_out <= SAT_HI[DAC_WIDTH-1:0];
            end else if (w_clip_lo) begin
                r_out <= SAT_LO[DAC_WIDTH-1:0];
            end else begin
                r_out <= r_v[DAC_WIDTH-1:0];
            end
            r_vld     <= {r_vld[L-2:0], 1'b1};
            r_sat_pos <= w_clip_hi | (r_sat_pos & ~clear_sat);
            r_sat_neg <= w_clip_lo | (r_sat_neg & ~clear_sat);
        end
    end

    assign m_axis_tdata  = AXIS_TDATA_WIDTH'(r_out);
    assign m_axis_tvalid = r_vld[L-1];
    assign ramp_state    = r_state;
    assign sat_pos       = r_sat_pos;
    assign sat_neg       = r_sat_neg;

endmodule

// File: tb/tb_fourier_synthesizer_ramped.sv
// Directed bench: gain/offset, latency, saturation, ramp envelope, reversal, N=3/N=1 builds, reset.
module tb_fourier_synthesizer_ramped;

    logic clk;
    logic reset;

    logic signed [15:0] d [4];
    logic [15:0]        a [4];
    logic [3:0]         tv;
    logic signed [13:0] ofs;
    logic               en;
    logic [15:0]        step;
    logic               clr;

    logic [63:0] s_tdata;
    logic [63:0] s_amp;
    logic [3:0]  s_tready;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic [1:0]  st;
    logic        spos, sneg;

    logic signed [15:0] dn;
    logic [47:0] s3_tdata;
    logic [2:0]  s3_tready;
    logic [15:0] m3_tdata;
    logic        m3_tvalid;
    logic [1:0]  st3;
    logic        spos3, sneg3;
    logic [0:0]  s1_tready;
    logic [15:0] m1_tdata;
    logic        m1_tvalid;
    logic [1:0]  st1;
    logic        spos1, sneg1;

    int n_checks = 0;
    int n_errors = 0;

    assign s_tdata  = {d[3], d[2], d[1], d[0]};
    assign s_amp    = {a[3], a[2], a[1], a[0]};
    assign s3_tdata = {dn, dn, dn};

    fourier_synthesizer_ramped dut (
        .clk(clk), .reset(reset), .s_axis_tdata(s_tdata), .s_axis_tvalid(tv),
        .s_axis_tready(s_tready), .amplitude(s_amp), .offset(ofs), .ramp_enable(en),
        .ramp_step(step), .clear_sat(clr), .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
        .ramp_state(st), .sat_pos(spos), .sat_neg(sneg)
    );

    fourier_synthesizer_ramped #(.N_CHANNELS(3)) dut3 (
        .clk(clk), .reset(reset), .s_axis_tdata(s3_tdata), .s_axis_tvalid(3'b111),
        .s_axis_tready(s3_tready), .amplitude({3{16'd8192}}), .offset(14'sd0),
        .ramp_enable(1'b1), .ramp_step(16'd0), .clear_sat(1'b0), .m_axis_tdata(m3_tdata),
        .m_axis_tvalid(m3_tvalid), .ramp_state(st3), .sat_pos(spos3), .sat_neg(sneg3)
    );

    fourier_synthesizer_ramped #(.N_CHANNELS(1)) dut1 (
        .clk(clk), .reset(reset), .s_axis_tdata(dn), .s_axis_tvalid(1'b1),
        .s_axis_tready(s1_tready), .amplitude(16'd8192), .offset(14'sd0),
        .ramp_enable(1'b1), .ramp_step(16'd0), .clear_sat(1'b0), .m_axis_tdata(m1_tdata),
        .m_axis_tvalid(m1_tvalid), .ramp_state(st1), .sat_pos(spos1), .sat_neg(sneg1)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d[i] = '0;
            a[i] = '0;
        end
        tv = '0; ofs = '0; en = 1'b0; step = '0; clr = 1'b0; dn = '0;

        tick(2);
        check_eq("rst_tdata", longint'($signed(m_tdata)), 0);
        check_eq("rst_tvalid", longint'(m_tvalid), 0);
        check_eq("rst_state", longint'(st), 0);
        check_eq("rst_sat_pos", longint'(spos), 0);
        check_eq("rst_sat_neg", longint'(sneg), 0);
        check_eq("tready", longint'(s_tready), 15);

        reset = 1'b0; en = 1'b1; ofs = 14'sd100; a[0] = 16'd8192;
        tick(1);
        check_eq("step0_on", longint'(st), 2);
        tick(2);
        check_eq("n1_tvalid_early", longint'(m1_tvalid), 0);
        tick(1);
        check_eq("n1_tvalid_rise", longint'(m1_tvalid), 1);
        tick(1);
        check_eq("tvalid_early", longint'(m_tvalid), 0);
        tick(1);
        check_eq("tvalid_rise", longint'(m_tvalid), 1);
        check_eq("offset_only", longint'($signed(m_tdata)), 100);

        // Gain/offset and the N=3 / N=1 latencies
        d[0] = 16'sd4000; tv = 4'b0001; dn = 16'sd1000;
        tick(3);
        check_eq("n1_lat_minus1", longint'($signed(m1_tdata)), 0);
        tick(1);
        check_eq("n1_sum", longint'($signed(m1_tdata)), 1000);
        tick(1);
        check_eq("gain_lat_minus1", longint'($signed(m_tdata)), 100);
        check_eq("n3_lat_minus1", longint'($signed(m3_tdata)), 0);
        tick(1);
        check_eq("gain_offset", longint'($signed(m_tdata)), 4100);
        check_eq("n3_sum", longint'($signed(m3_tdata)), 3000);
        check_eq("gain_no_pos", longint'(spos), 0);
        check_eq("gain_no_neg", longint'(sneg), 0);

        ofs = -14'sd100;
        tick(1);
        check_eq("offset_lat1", longint'($signed(m_tdata)), 4100);
        tick(1);
        check_eq("offset_lat2", longint'($signed(m_tdata)), 3900);
        ofs = '0;

        // Saturation
        d[0] = 16'sd32767; d[1] = 16'sd32767; tv = 4'b0011; a[1] = 16'd8192;
        tick(6);
        check_eq("sat_hi_value", longint'($signed(m_tdata)), 8191);
        check_eq("sat_hi_flag", longint'(spos), 1);
        check_eq("sat_hi_neg_clear", longint'(sneg), 0);
        d[0] = -16'sd32768; d[1] = -16'sd32768;
        tick(6);
        check_eq("sat_lo_value", longint'($signed(m_tdata)), -8192);
        check_eq("sat_lo_flag", longint'(sneg), 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check_eq("clear_vs_set", longint'(sneg), 1);
        check_eq("clear_pos", longint'(spos), 0);
        d[0] = '0; d[1] = '0;
        tick(6);
        check_eq("no_clip_value", longint'($signed(m_tdata)), 0);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check_eq("clear_neg", longint'(sneg), 0);

        // Ramp up and down
        d[0] = 16'sd4000; tv = 4'b0001; en = 1'b0;
        tick(1);
        check_eq("step0_off", longint'(st), 0);
        tick(6);
        check_eq("off_output", longint'($signed(m_tdata)), 0);
        step = 16'd16384; en = 1'b1;
        tick(1);
        check_eq("up_state1", longint'(st), 1);
        tick(1);
        check_eq("up_state2", longint'(st), 1);
        tick(1);
        check_eq("up_state3", longint'(st), 1);
        check_eq("up_out_pre", longint'($signed(m_tdata)), 0);
        tick(1);
        check_eq("up_state_on", longint'(st), 2);
        check_eq("up_out1", longint'($signed(m_tdata)), 1000);
        tick(1);
        check_eq("up_out2", longint'($signed(m_tdata)), 2000);
        tick(1);
        check_eq("up_out3", longint'($signed(m_tdata)), 3000);
        tick(1);
        check_eq("up_out4", longint'($signed(m_tdata)), 4000);
        en = 1'b0;
        tick(3);
        check_eq("down_state", longint'(st), 3);
        check_eq("down_out_pre", longint'($signed(m_tdata)), 4000);
        tick(1);
        check_eq("down_state_off", longint'(st), 0);
        check_eq("down_out1", longint'($signed(m_tdata)), 3000);
        tick(1);
        check_eq("down_out2", longint'($signed(m_tdata)), 2000);
        tick(1);
        check_eq("down_out3", longint'($signed(m_tdata)), 1000);
        tick(1);
        check_eq("down_out4", longint'($signed(m_tdata)), 0);

        // Reversal: output = acc/16 with data 4096, amp 8192
        d[0] = 16'sd4096; step = 16'd1000; en = 1'b1;
        tick(30);
        check_eq("rev_up_state", longint'(st), 1);
        en = 1'b0;
        tick(1);
        check_eq("rev_down_state", longint'(st), 3);
        en = 1'b1;
        tick(1);
        check_eq("rev_reup_state", longint'(st), 1);
        check_eq("rev_out_29000", longint'($signed(m_tdata)), 1812);
        tick(1);
        check_eq("rev_out_30000", longint'($signed(m_tdata)), 1875);
        tick(1);
        check_eq("rev_out_down", longint'($signed(m_tdata)), 1812);
        tick(1);
        check_eq("rev_out_reup", longint'($signed(m_tdata)), 1875);
        tick(1);
        check_eq("rev_out_31000", longint'($signed(m_tdata)), 1937);

        // Mid-run reset
        step = '0;
        tick(1);
        check_eq("pre_rst_on", longint'(st), 2);
        tick(6);
        check_eq("pre_rst_out", longint'($signed(m_tdata)), 4096);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_eq("mid_rst_tdata", longint'($signed(m_tdata)), 0);
        check_eq("mid_rst_tvalid", longint'(m_tvalid), 0);
        check_eq("mid_rst_state", longint'(st), 0);
        check_eq("mid_rst_n3_tdata", longint'($signed(m3_tdata)), 0);
        tick(5);
        check_eq("mid_rst_tvalid_early", longint'(m_tvalid), 0);
        tick(1);
        check_eq("mid_rst_tvalid_rise", longint'(m_tvalid), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
